// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer for the kianv rv32im core: fetch/decode/execute/memory/writeback
// strobes, optional M-extension dispatch, sticky halt on illegal opcode. Define BUS_TIMEOUT_EN for the memory watchdog.
module mc_control_fsm #(
   parameter int MULDIV      = 1,
   parameter int TIMEOUT_W   = 8,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [6:0] op,
   input  logic       funct7b0,
   input  logic       Zero,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ResultSrc,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       ALUOutWrite,
   output logic       mem_valid,
   input  logic       mem_ready,
   output logic       alu_valid,
   input  logic       alu_ready,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic       halted
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_BUS     = 2'd2;

   typedef enum logic [4:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_LOAD, S_MEMWB, S_STORE, S_EXECR, S_EXECI, S_MULDIV,
      S_ALUWB, S_JAL, S_JALR, S_BRANCH, S_LUI, S_AUIPC, S_ILLEGAL, S_HALT
   } state_t;

   if (MEM_TIMEOUT >= (1 << TIMEOUT_W)) begin : g_bad_cfg
      $error("MEM_TIMEOUT must be below 2**TIMEOUT_W");
   end

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_trap_cause;
   logic       w_pc_update;
   logic       w_branch;
   logic       w_trap;
   logic [1:0] w_cause;
   logic       w_tmo;

`ifdef BUS_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] r_tmo_cnt;
   logic                 w_mem_wait;

   assign w_mem_wait = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_STORE);
   // Fires on the MEM_TIMEOUT-th unanswered cycle; a mem_ready in that same cycle takes priority.
   assign w_tmo = w_mem_wait && !mem_ready && (r_tmo_cnt == TIMEOUT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tmo_cnt <= '0;
      end else if (w_mem_wait && !mem_ready && !w_tmo) begin
         r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
      end else begin
         r_tmo_cnt <= '0;
      end
   end
`else
   assign w_tmo = 1'b0;
`endif

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values together.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_FETCH;
         r_trap_cause <= 2'd0;
      end else begin
         r_state <= w_next;
         if (w_trap) begin
            r_trap_cause <= w_cause;
         end
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      w_next      = r_state;
      w_pc_update = 1'b0;
      w_branch    = 1'b0;
      w_trap      = 1'b0;
      w_cause     = 2'd0;
      AdrSrc      = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 2'd0;
      ALUSrcB     = 2'd0;
      ALUOp       = 2'd0;
      ResultSrc   = 2'd0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      ALUOutWrite = 1'b0;
      mem_valid   = 1'b0;
      alu_valid   = 1'b0;
      halted      = 1'b0;

      case (r_state)
         S_FETCH: begin
            mem_valid = 1'b1;
            if (w_tmo) begin
               w_trap  = 1'b1;
               w_cause = CAUSE_BUS;
               w_next  = S_HALT;
            end else if (mem_ready) begin
               IRWrite     = 1'b1;
               ALUSrcB     = 2'd2;
               w_pc_update = 1'b1;
               w_next      = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA     = 2'd1;
            ALUSrcB     = 2'd1;
            ALUOutWrite = 1'b1;
            case (op)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_RTYPE: begin
                  if (!funct7b0)        w_next = S_EXECR;
                  else if (MULDIV != 0) w_next = S_MULDIV;
                  else                  w_next = S_ILLEGAL;
               end
               OP_ITYPE:  w_next = S_EXECI;
               OP_JAL:    w_next = S_JAL;
               OP_JALR:   w_next = S_JALR;
               OP_BRANCH: w_next = S_BRANCH;
               OP_LUI:    w_next = S_LUI;
               OP_AUIPC:  w_next = S_AUIPC;
               default:   w_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA     = 2'd2;
            ALUSrcB     = 2'd1;
            ALUOutWrite = 1'b1;
            w_next      = op[5] ? S_STORE : S_LOAD;
         end
         S_LOAD, S_STORE: begin
            AdrSrc    = 1'b1;
            mem_valid = 1'b1;
            MemWrite  = (r_state == S_STORE);
            if (w_tmo) begin
               w_trap  = 1'b1;
               w_cause = CAUSE_BUS;
               w_next  = S_HALT;
            end else if (mem_ready) begin
               w_next = (r_state == S_STORE) ? S_FETCH : S_MEMWB;
            end
         end
         S_MEMWB: begin
            ResultSrc = 2'd1;
            RegWrite  = 1'b1;
            w_next    = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            ALUSrcA     = 2'd2;
            ALUSrcB     = (r_state == S_EXECI) ? 2'd1 : 2'd0;
            ALUOp       = 2'd2;
            ALUOutWrite = 1'b1;
            w_next      = S_ALUWB;
         end
         S_MULDIV: begin
            ALUSrcA   = 2'd2;
            ALUOp     = 2'd2;
            alu_valid = 1'b1;
            if (alu_ready) begin
               ALUOutWrite = 1'b1;
               w_next      = S_ALUWB;
            end
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            w_next   = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA     = 2'd1;
            ALUSrcB     = 2'd2;
            ALUOutWrite = 1'b1;
            w_pc_update = 1'b1;
            w_next      = S_ALUWB;
         end
         S_JALR: begin
            ALUSrcA     = 2'd2;
            ALUSrcB     = 2'd1;
            ALUOutWrite = 1'b1;
            w_next      = S_JAL;
         end
         S_BRANCH: begin
            ALUSrcA  = 2'd2;
            ALUOp    = 2'd1;
            w_branch = 1'b1;
            w_next   = S_FETCH;
         end
         S_LUI, S_AUIPC: begin
            ALUSrcA     = (r_state == S_AUIPC) ? 2'd1 : 2'd0;
            ALUSrcB     = 2'd1;
            ALUOutWrite = 1'b1;
            w_next      = S_ALUWB;
         end
         S_ILLEGAL: begin
            w_trap  = 1'b1;
            w_cause = CAUSE_ILLEGAL;
            w_next  = S_HALT;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase

      PCWrite    = (w_branch & ~Zero) | w_pc_update;
      trap       = w_trap;
      trap_cause = w_trap ? w_cause : r_trap_cause;

      // NOTE: outputs are forced low while resetn is low so an in-flight request aborts without waiting for a clock.
      if (!resetn) begin
         AdrSrc      = 1'b0;
         IRWrite     = 1'b0;
         ALUSrcA     = 2'd0;
         ALUSrcB     = 2'd0;
         ALUOp       = 2'd0;
         ResultSrc   = 2'd0;
         PCWrite     = 1'b0;
         RegWrite    = 1'b0;
         MemWrite    = 1'b0;
         ALUOutWrite = 1'b0;
         mem_valid   = 1'b0;
         alu_valid   = 1'b0;
         trap        = 1'b0;
         trap_cause  = 2'd0;
         halted      = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: a per-instruction trace model predicts every cycle's strobes
// from the instruction class and the randomly chosen handshake delays.
`timescale 1ns/1ps
module tb_mc_control_fsm;

   localparam int TMO = 15;
`ifdef BUS_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   typedef struct packed {
      logic       adr_src;
      logic       ir_write;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] alu_op;
      logic [1:0] res_src;
      logic       pc_write;
      logic       reg_write;
      logic       mem_write;
      logic       alu_out_write;
      logic       mem_valid;
      logic       alu_valid;
      logic       trap;
      logic [1:0] trap_cause;
      logic       halted;
   } out_t;

   typedef struct packed {
      logic mr;
      logic ar;
      logic z;
      out_t o;
   } step_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [6:0] op = 7'd0;
   logic       funct7b0 = 1'b0;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       alu_ready = 1'b0;

   logic       adr1, irw1, pcw1, rw1, mw1, aow1, mv1, av1, trap1, halt1;
   logic [1:0] sa1, sb1, aop1, rs1, tc1;
   logic       adr0, irw0, pcw0, rw0, mw0, aow0, mv0, av0, trap0, halt0;
   logic [1:0] sa0, sb0, aop0, rs0, tc0;
   out_t       obs1, obs0;

   assign obs1 = {adr1, irw1, sa1, sb1, aop1, rs1, pcw1, rw1, mw1, aow1, mv1, av1, trap1, tc1, halt1};
   assign obs0 = {adr0, irw0, sa0, sb0, aop0, rs0, pcw0, rw0, mw0, aow0, mv0, av0, trap0, tc0, halt0};

   always #5 clk = ~clk;

   mc_control_fsm #(.MULDIV(1), .TIMEOUT_W(8), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .resetn(resetn), .op(op), .funct7b0(funct7b0), .Zero(Zero),
      .AdrSrc(adr1), .IRWrite(irw1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(aop1), .ResultSrc(rs1),
      .PCWrite(pcw1), .RegWrite(rw1), .MemWrite(mw1), .ALUOutWrite(aow1), .mem_valid(mv1),
      .mem_ready(mem_ready), .alu_valid(av1), .alu_ready(alu_ready), .trap(trap1),
      .trap_cause(tc1), .halted(halt1)
   );

   mc_control_fsm #(.MULDIV(0), .TIMEOUT_W(8), .MEM_TIMEOUT(TMO)) dut_nomul (
      .clk(clk), .resetn(resetn), .op(op), .funct7b0(funct7b0), .Zero(Zero),
      .AdrSrc(adr0), .IRWrite(irw0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(aop0), .ResultSrc(rs0),
      .PCWrite(pcw0), .RegWrite(rw0), .MemWrite(mw0), .ALUOutWrite(aow0), .mem_valid(mv0),
      .mem_ready(mem_ready), .alu_valid(av0), .alu_ready(alu_ready), .trap(trap0),
      .trap_cause(tc0), .halted(halt0)
   );

   int    n_checks = 0;
   int    n_err = 0;
   step_t q[$];
   logic [1:0] cur_cause = 2'd0;
   bit    halted_m = 1'b0;

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic out_t base();
      out_t o = '0;
      o.trap_cause = cur_cause;
      return o;
   endfunction

   task automatic check(input string tag, input out_t got, input out_t exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input out_t o, input logic mr, input logic ar, input logic z);
      step_t s;
      s.o = o; s.mr = mr; s.ar = ar; s.z = z;
      q.push_back(s);
   endtask

   task automatic model_halt(input int n);
      out_t o = base();
      o.halted = 1'b1;
      halted_m = 1'b1;
      for (int i = 0; i < n; i++) push(o, rb(), rb(), rb());
   endtask

   // kind: 0 = instruction fetch, 1 = load, 2 = store; delay = cycles before mem_ready
   task automatic model_mem(input int kind, input int delay, output bit trapped);
      out_t o = base();
      o.mem_valid = 1'b1;
      o.adr_src   = (kind != 0);
      o.mem_write = (kind == 2);
      trapped = 1'b0;
      for (int i = 0; i < delay; i++) begin
         if (TMO_EN && i == TMO - 1) begin
            o.trap = 1'b1;
            o.trap_cause = 2'd2;
            push(o, 1'b0, rb(), rb());
            cur_cause = 2'd2;
            trapped = 1'b1;
            return;
         end
         push(o, 1'b0, rb(), rb());
      end
      if (kind == 0) begin
         o.ir_write = 1'b1;
         o.src_b    = 2'd2;
         o.pc_write = 1'b1;
      end
      push(o, 1'b1, rb(), rb());
   endtask

   task automatic model_wb(input logic [1:0] res);
      out_t o = base();
      o.res_src   = res;
      o.reg_write = 1'b1;
      push(o, rb(), rb(), rb());
   endtask

   task automatic model_alu(input logic [1:0] a, input logic [1:0] b, input logic [1:0] aop, input bit pcw);
      out_t o = base();
      o.src_a = a; o.src_b = b; o.alu_op = aop; o.alu_out_write = 1'b1; o.pc_write = pcw;
      push(o, rb(), rb(), rb());
   endtask

   task automatic model_instr(input logic [6:0] opc, input logic f7, input logic z, input bit muldiv,
                              input int fd, input int md, input int ad, input int nhalt);
      out_t o;
      bit   tr;
      model_mem(0, fd, tr);
      if (tr) begin model_halt(nhalt); return; end
      model_alu(2'd1, 2'd1, 2'd0, 1'b0);
      case (opc)
         7'b0000011, 7'b0100011: begin
            model_alu(2'd2, 2'd1, 2'd0, 1'b0);
            model_mem(opc[5] ? 2 : 1, md, tr);
            if (tr) begin model_halt(nhalt); return; end
            if (!opc[5]) model_wb(2'd1);
         end
         7'b0110011: begin
            if (!f7) begin
               model_alu(2'd2, 2'd0, 2'd2, 1'b0);
               model_wb(2'd0);
            end else if (muldiv) begin
               o = base();
               o.src_a = 2'd2; o.alu_op = 2'd2; o.alu_valid = 1'b1;
               for (int i = 0; i < ad; i++) push(o, rb(), 1'b0, rb());
               o.alu_out_write = 1'b1;
               push(o, rb(), 1'b1, rb());
               model_wb(2'd0);
            end else begin
               o = base(); o.trap = 1'b1; o.trap_cause = 2'd1;
               push(o, rb(), rb(), rb());
               cur_cause = 2'd1;
               model_halt(nhalt);
            end
         end
         7'b0010011: begin model_alu(2'd2, 2'd1, 2'd2, 1'b0); model_wb(2'd0); end
         7'b1101111: begin model_alu(2'd1, 2'd2, 2'd0, 1'b1); model_wb(2'd0); end
         7'b1100111: begin
            model_alu(2'd2, 2'd1, 2'd0, 1'b0);
            model_alu(2'd1, 2'd2, 2'd0, 1'b1);
            model_wb(2'd0);
         end
         7'b1100011: begin
            o = base(); o.src_a = 2'd2; o.alu_op = 2'd1; o.pc_write = ~z;
            push(o, rb(), rb(), z);
         end
         7'b0110111: begin model_alu(2'd0, 2'd1, 2'd0, 1'b0); model_wb(2'd0); end
         7'b0010111: begin model_alu(2'd1, 2'd1, 2'd0, 1'b0); model_wb(2'd0); end
         default: begin
            o = base(); o.trap = 1'b1; o.trap_cause = 2'd1;
            push(o, rb(), rb(), rb());
            cur_cause = 2'd1;
            model_halt(nhalt);
         end
      endcase
   endtask

   // Plays the queued trace one cycle at a time against the selected instance.
   task automatic run_q(input string name, input bit sel_nomul);
      int idx = 0;
      while (q.size() > 0) begin
         step_t s = q.pop_front();
         mem_ready = s.mr; alu_ready = s.ar; Zero = s.z;
         #1;
         check($sformatf("%s#%0d", name, idx), sel_nomul ? obs0 : obs1, s.o);
         idx++;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset(input string name);
      resetn = 1'b0;
      #1;
      check({name, "_rst"}, obs1, '0);
      check({name, "_rst_nomul"}, obs0, '0);
      @(posedge clk); #1;
      resetn = 1'b1;
      mem_ready = 1'b0; alu_ready = 1'b0;
      cur_cause = 2'd0;
      halted_m = 1'b0;
   endtask

   task automatic directed(input string name, input logic [31:0] ir, input logic z, input bit sel_nomul,
                           input int fd, input int md, input int ad, input int nhalt);
      op = ir[6:0]; funct7b0 = ir[25];
      model_instr(ir[6:0], ir[25], z, !sel_nomul, fd, md, ad, nhalt);
      run_q(name, sel_nomul);
   endtask

   logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                                 7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};

   initial begin
      do_reset("init");
      directed("addi", 32'h00500093, 1'b0, 1'b0, 3, 0, 0, 0);
      directed("lw", 32'h0000a103, 1'b0, 1'b0, 1, 10, 0, 0);
      directed("sw", 32'h0020a023, 1'b0, 1'b0, 0, 4, 0, 0);
      directed("mul", 32'h02208033, 1'b0, 1'b0, 2, 0, 32, 0);
      do_reset("pre_nomul");
      directed("mul_nomul", 32'h02208033, 1'b0, 1'b1, 1, 0, 0, 5);
      do_reset("post_nomul");
      directed("beq_nz", 32'h00208063, 1'b0, 1'b0, 0, 0, 0, 0);
      directed("beq_z", 32'h00208063, 1'b1, 1'b0, 2, 0, 0, 0);
      directed("jalr", 32'h000080e7, 1'b0, 1'b0, 0, 0, 0, 0);
      directed("illegal", 32'h0000007f, 1'b0, 1'b0, 1, 0, 0, 100);
      do_reset("post_halt");

      // Reset asserted mid-wait must drop mem_valid immediately.
      op = 7'b0000011; funct7b0 = 1'b0;
      model_mem(1'b0, 3, halted_m);
      void'(q.pop_back());
      run_q("midwait", 1'b0);
      do_reset("abort");

`ifdef BUS_TIMEOUT_EN
      directed("bus_tmo", 32'h00500093, 1'b0, 1'b0, TMO + 5, 0, 0, 5);
      do_reset("post_tmo");
      directed("bus_edge", 32'h00500093, 1'b0, 1'b0, TMO - 1, 0, 0, 0);
      directed("ld_tmo", 32'h0000a103, 1'b0, 1'b0, 0, TMO + 2, 0, 4);
      do_reset("post_ldtmo");
`endif

      for (int n = 0; n < 250; n++) begin
         logic [31:0] ir;
         ir = $urandom;
         if ($urandom_range(0, 19) != 0) ir[6:0] = legal_ops[$urandom_range(0, 8)];
         op = ir[6:0]; funct7b0 = ir[25];
         model_instr(ir[6:0], ir[25], rb(), 1'b1, $urandom_range(0, 6), $urandom_range(0, 6),
                     $urandom_range(0, 8), 3);
         run_q($sformatf("rnd%0d", n), 1'b0);
         if (halted_m) do_reset("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised multicycle sequencer for the kianv rv32im core, successor to the single-mode control unit.
- Decodes opcode/funct bits and drives datapath strobes through the fetch, decode, execute, memory and writeback states.
- Adds two new behaviours: a selectable M-extension mode, and illegal-instruction detection with a sticky halt.
- Sits between the instruction register/ALU/memory datapath and the memory and multi-cycle ALU handshakes.

Parameters:
- MULDIV, 1: 1 = R-type with funct7b0=1 routed to MULDIV state; 0 = such instructions are illegal.
- TIMEOUT_W, 8: width of the memory-wait watchdog counter (used only with BUS_TIMEOUT_EN).
- MEM_TIMEOUT, 255: cycles mem_valid may stay unanswered before a bus trap; must be < 2^TIMEOUT_W.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- op  in  7  instruction opcode (IR[6:0])
- funct7b0  in  1  IR[25], M-extension select
- Zero  in  1  ALU zero flag; branch taken when 0 (compare result nonzero)
- AdrSrc  out  1  0 = PC, 1 = ALUOut address
- IRWrite  out  1  latch instruction
- ALUSrcA  out  2  0 = PC, 1 = OldPC, 2 = rs1 register
- ALUSrcB  out  2  0 = rs2 register, 1 = immediate, 2 = constant 4
- ALUOp  out  2  0 = add, 1 = sub/compare, 2 = decode by funct
- ResultSrc  out  2  0 = ALUOut, 1 = memory data, 2 = ALU result
- PCWrite  out  1  (Branch & !Zero) | PCUpdate
- RegWrite  out  1  register file write
- MemWrite  out  1  store strobe, valid with mem_valid
- ALUOutWrite  out  1  latch ALU result
- mem_valid  out  1  memory request
- mem_ready  in  1  memory completion
- alu_valid  out  1  multi-cycle ALU request
- alu_ready  in  1  multi-cycle ALU done
- trap  out  1  one-cycle pulse on fault
- trap_cause  out  2  1 = illegal opcode, 2 = bus timeout; held until next trap or reset
- halted  out  1  sticky; core is stopped

Behaviour:
- Reset (async, resetn=0): state=FETCH, trap_cause=0, timeout counter=0. All strobes are 0 and all selects are 0 during reset.
- FETCH: AdrSrc=0, mem_valid=1.
  - On mem_ready: IRWrite=1, ALUSrcA=0, ALUSrcB=2, ALUOp=0, PCUpdate=1; next state DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=1, ALUOp=0, ALUOutWrite=1. Dispatch on op:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR, or MULDIV when funct7b0=1 and MULDIV=1
  - 0010011 → EXECI; 1101111 → JAL; 1100111 → JALR; 1100011 → BRANCH
  - 0110111 → LUI; 0010111 → AUIPC
  - anything else (including M-op with MULDIV=0) → ILLEGAL
- MEMADR: ALUSrcA=2, ALUSrcB=1, ALUOutWrite=1; next LOAD or STORE by op[5].
- LOAD: AdrSrc=1, mem_valid=1; wait for mem_ready, then MEMWB.
- MEMWB: ResultSrc=1, RegWrite=1; next FETCH.
- STORE: AdrSrc=1, mem_valid=1, MemWrite=1; on mem_ready → FETCH.
- EXECR: ALUSrcA=2, ALUSrcB=0, ALUOp=2, ALUOutWrite=1; next ALUWB.
- EXECI: same as EXECR but ALUSrcB=1.
- MULDIV: ALUSrcA=2, ALUSrcB=0, ALUOp=2, alu_valid=1 held until alu_ready; on alu_ready ALUOutWrite=1, next ALUWB.
- ALUWB: ResultSrc=0, RegWrite=1; next FETCH.
- JAL: ALUSrcA=1, ALUSrcB=2, ALUOutWrite=1, ResultSrc=0, PCUpdate=1; next ALUWB.
- JALR: first cycle ALUSrcA=2, ALUSrcB=1, ALUOutWrite=1; next JAL.
- BRANCH: ALUSrcA=2, ALUSrcB=0, ALUOp=1, ResultSrc=0, Branch=1; next FETCH.
- LUI / AUIPC: ALUSrcA=0 for LUI (datapath masks) or 1 for AUIPC, ALUSrcB=1, ALUOutWrite=1; next ALUWB.
- ILLEGAL: trap=1, trap_cause=1; next HALT.
- HALT: all strobes 0, halted=1; leaves only on reset.
- Handshake rules:
  - mem_valid and MemWrite are held stable until the mem_ready cycle.
  - mem_ready without mem_valid is ignored.
  - mem_ready and alu_ready are sampled only in their waiting states.
- Reset mid-wait aborts the transaction immediately: mem_valid drops asynchronously.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - Counter increments each cycle mem_valid=1 without mem_ready, and clears on mem_ready or on leaving the state.
  - When count reaches MEM_TIMEOUT with mem_ready still 0: drop mem_valid, trap=1, trap_cause=2, enter HALT.
  - mem_ready in the same cycle as the limit wins; no trap.
- Undefined: no counter, waits are unbounded, trap_cause never 2.

Test Plan:
- Reset, then fetch of addi x1,x0,5 (0x00500093) with mem_ready after 3 cycles → IRWrite one cycle, state path FETCH→DECODE→EXECI→ALUWB, RegWrite in cycle 4 after ready.
- lw with mem_ready delayed 10 cycles → mem_valid=1, AdrSrc=1 held all 10 cycles, then MEMWB with ResultSrc=1, RegWrite=1.
- mul (0x02208033): MULDIV=1 with alu_ready after 32 cycles → alu_valid high 32 cycles, then ALUWB. MULDIV=0 → trap pulse, trap_cause=1, halted=1.
- beq with Zero=0 then Zero=1 → PCWrite=1 and 0 respectively in the BRANCH cycle.
- Opcode 0x7F → trap=1 for exactly one cycle, halted stays 1 for 100 cycles, cleared by resetn=0.
- BUS_TIMEOUT_EN, MEM_TIMEOUT=15, mem_ready never asserted → trap on the 15th wait cycle, trap_cause=2. With mem_ready on exactly cycle 15 → no trap.
